fp_mul_rr_sched: RTL and testbench

//  Round-robin scheduler sharing one FP32 multiplier datapath between N_REQ requesters.
//  - Accepts one operation per grant and holds operands stable on the multiplier inputs for MUL_LAT cycles.
//  - Captures fp_Z/ovrf/udrf and returns them to the winning requester over a valid/ready response channel.
//  - Sits between the FPU issue logic and the multiplier core; only one operation is outstanding at a time.

---
 rtl/fp_mul_rr_sched.sv | 155 +++++++++++++++
 tb/tb_fp_mul_rr_sched.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_rr_sched.sv
// Round-robin scheduler sharing one FP32 multiplier between N_REQ requesters.
// One operation outstanding at a time: grant, hold operands MUL_LAT cycles,
// capture the result, return it on a per-requester valid/ready channel.
module fp_mul_rr_sched #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_x,
  input  logic [32*N_REQ-1:0]  req_y,
  input  logic [3*N_REQ-1:0]   req_rmode,
  output logic [31:0]          mul_x,
  output logic [31:0]          mul_y,
  output logic [2:0]           mul_rmode,
  input  logic [31:0]          mul_z,
  input  logic                 mul_ovrf,
  input  logic                 mul_udrf,
  output logic [N_REQ-1:0]     rsp_valid,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic [31:0]          rsp_z,
  output logic                 rsp_ovrf,
  output logic                 rsp_udrf,
  output logic                 rsp_badrm
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LAT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   cur;
  logic            gnt_found;
  logic [N_REQ-1:0] gnt_oh;
  logic [31:0]     sel_x, sel_y;
  logic [2:0]      sel_rm;
  logic            sel_bad;
  logic [CW-1:0]   cnt;
  logic            bad_q;
  logic            accept, rsp_hs;

  // First valid requester searching upward from rr_ptr, with wrap
  always_comb begin : p_search
    int unsigned idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!gnt_found && req_valid[IW'(idx)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(idx);
      end
    end
  end

  // Operand mux and one-hot grant for the winning requester
  always_comb begin
    sel_x  = '0;
    sel_y  = '0;
    sel_rm = '0;
    gnt_oh = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (IW'(j) == gnt_idx) begin
        sel_x     = req_x[32*j +: 32];
        sel_y     = req_y[32*j +: 32];
        sel_rm    = req_rmode[3*j +: 3];
        gnt_oh[j] = gnt_found;
      end
    end
    sel_bad = (sel_rm > 3'd4);
  end

  // Grant is only offered in IDLE and is forced low while reset is asserted
  assign req_ready = (state == IDLE && !rst) ? gnt_oh : '0;
  assign accept    = (state == IDLE) && gnt_found;
  assign rsp_hs    = (state == RESP) && ((rsp_ready & rsp_valid) != '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)     state_nxt = BUSY;
      BUSY:    if (cnt == '0)  state_nxt = RESP;
      RESP:    if (rsp_hs)     state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Operand latch, latency counter, round-robin pointer and response capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      cur       <= '0;
      cnt       <= '0;
      bad_q     <= 1'b0;
      mul_x     <= '0;
      mul_y     <= '0;
      mul_rmode <= '0;
      rsp_valid <= '0;
      rsp_z     <= '0;
      rsp_ovrf  <= 1'b0;
      rsp_udrf  <= 1'b0;
      rsp_badrm <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            mul_x     <= sel_x;
            mul_y     <= sel_y;
            mul_rmode <= sel_bad ? 3'd0 : sel_rm;
            bad_q     <= sel_bad;
            cur       <= gnt_idx;
            cnt       <= CNT_INIT;
            rr_ptr    <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IW'(1);
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            rsp_z     <= mul_z;
            rsp_ovrf  <= mul_ovrf;
            rsp_udrf  <= mul_udrf;
            rsp_badrm <= bad_q;
            rsp_valid <= N_REQ'(1) << cur;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (rsp_hs) rsp_valid <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_rr_sched.sv
// Bench for fp_mul_rr_sched: directed vector table, reset/stall sequences and a
// randomized transaction-level run against a behavioural scheduler model.
module tb_fp_mul_rr_sched;

  localparam int N = 3;
  localparam int L = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [32*N-1:0]   req_x, req_y;
  logic [3*N-1:0]    req_rmode;
  logic [31:0]       mul_x, mul_y, mul_z, rsp_z;
  logic [2:0]        mul_rmode;
  logic              mul_ovrf, mul_udrf, rsp_ovrf, rsp_udrf, rsp_badrm;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  // Scheduler model state
  int           mptr;
  logic [N-1:0] pend;
  logic [31:0]  px [N];
  logic [31:0]  py [N];
  logic [2:0]   prm [N];
  bit           ost;
  int           og, t_acc;
  logic [31:0]  ox, oy;
  logic [2:0]   orm;
  int           grant_log[$];

  typedef struct {
    int          req;
    logic [31:0] x, y;
    logic [2:0]  rm;
    logic [31:0] ez;
    logic        eov, eud, ebad;
    logic [2:0]  emrm;
    int          hold;
  } vec_t;
  vec_t tbl[7];

  fp_mul_rr_sched #(.N_REQ(N), .MUL_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_rmode(req_rmode),
    .mul_x(mul_x), .mul_y(mul_y), .mul_rmode(mul_rmode),
    .mul_z(mul_z), .mul_ovrf(mul_ovrf), .mul_udrf(mul_udrf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_z(rsp_z), .rsp_ovrf(rsp_ovrf), .rsp_udrf(rsp_udrf), .rsp_badrm(rsp_badrm)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  // Stand-in multiplier: two exact FP cases, otherwise an easy-to-predict sum
  function automatic logic [33:0] ref_mul(logic [31:0] x, logic [31:0] y, logic [2:0] rm);
    logic [32:0] s;
    if (x == 32'h40400000 && y == 32'h40400000) return {2'b00, 32'h41100000};
    if (x == 32'h7F000000 && y == 32'h7F000000) return {2'b01, 32'h7F800000};
    s = 33'(x) + 33'(y) + 33'(rm);
    return {(x == 32'd0 || y == 32'd0), s[32], s[31:0]};
  endfunction

  assign {mul_udrf, mul_ovrf, mul_z} = ref_mul(mul_x, mul_y, mul_rmode);

  function automatic logic [2:0] eff(logic [2:0] rm);
    return (rm > 3'd4) ? 3'd0 : rm;
  endfunction

  function automatic logic [N-1:0] oh(int i);
    logic [N-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic int rr_pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
    req_x[32*i +: 32]   = x;
    req_y[32*i +: 32]   = y;
    req_rmode[3*i +: 3] = rm;
  endtask

  // One directed operation from a lone requester, with an optional response stall
  task automatic single_op(input vec_t v);
    bit got;
    logic [31:0] z0;
    @(posedge clk); #1;
    set_req(v.req, v.x, v.y, v.rm);
    req_valid = oh(v.req);
    got = 0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clk);
      if (req_ready != '0) got = 1;
      else begin @(posedge clk); #1; end
    end
    chk("grant", 32'(req_ready), 32'(oh(v.req)));
    if (!got) begin req_valid = '0; return; end
    @(posedge clk); #1;
    // Everyone requests with scrambled operands while the op is in flight
    req_valid = '1;
    for (int i = 0; i < N; i++) set_req(i, $urandom, $urandom, 3'($urandom_range(0, 7)));
    for (int k = 0; k < L; k++) begin
      @(negedge clk);
      chk("busy_rsp_valid", 32'(rsp_valid), 0);
      chk("busy_req_ready", 32'(req_ready), 0);
      chk("busy_mul_x", mul_x, v.x);
      chk("busy_mul_y", mul_y, v.y);
      chk("busy_mul_rmode", 32'(mul_rmode), 32'(v.emrm));
    end
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'(oh(v.req)));
    chk("rsp_z", rsp_z, v.ez);
    chk("rsp_ovrf", 32'(rsp_ovrf), 32'(v.eov));
    chk("rsp_udrf", 32'(rsp_udrf), 32'(v.eud));
    chk("rsp_badrm", 32'(rsp_badrm), 32'(v.ebad));
    z0 = rsp_z;
    for (int h = 0; h < v.hold; h++) begin
      rsp_ready = ~oh(v.req);
      @(negedge clk);
      chk("stall_rsp_valid", 32'(rsp_valid), 32'(oh(v.req)));
      chk("stall_rsp_z", rsp_z, z0);
      chk("stall_req_ready", 32'(req_ready), 0);
    end
    rsp_ready = oh(v.req);
    @(posedge clk); #1;
    rsp_ready = '0;
    @(negedge clk);
    chk("post_rsp_valid", 32'(rsp_valid), 0);
    chk("resume_grant", 32'(req_ready), 32'(oh((v.req + 1) % N)));
    req_valid = '0;
    mptr = (v.req + 1) % N;
  endtask

  // Random traffic checked transaction by transaction against the model
  task automatic run_random(input int ncyc, input logic [N-1:0] mask,
                            input int p_new, input int p_rdy, input int p_drop);
    int g;
    logic [33:0] r;
    int limit;
    limit = ncyc + 100;
    pend = '0;
    ost  = 0;
    for (int c = 0; c < limit; c++) begin
      if (c >= ncyc && !ost) break;
      @(negedge clk);
      rsp_ready = '0;
      for (int i = 0; i < N; i++) begin
        if (c >= ncyc) pend[i] = 1'b0;
        else if (mask[i]) begin
          if (!pend[i] && $urandom_range(0, 99) < p_new) begin
            pend[i] = 1'b1;
            px[i] = $urandom;
            py[i] = $urandom;
            prm[i] = 3'($urandom_range(0, 7));
          end else if (pend[i] && $urandom_range(0, 99) < p_drop) begin
            pend[i] = 1'b0;
          end
        end
        if (pend[i]) set_req(i, px[i], py[i], prm[i]);
        else set_req(i, $urandom, $urandom, 3'($urandom_range(0, 7)));
      end
      req_valid = pend;
      #1;
      if (!ost) begin
        g = rr_pick(pend, mptr);
        chk("idle_rsp_valid", 32'(rsp_valid), 0);
        if (g < 0) chk("rr_none", 32'(req_ready), 0);
        else begin
          chk("rr_grant", 32'(req_ready), 32'(oh(g)));
          ost = 1; og = g; ox = px[g]; oy = py[g]; orm = prm[g];
          t_acc = edge_n + 1;
          mptr = (g + 1) % N;
          pend[g] = 1'b0;
          grant_log.push_back(g);
        end
      end else begin
        chk("rr_busy_ready", 32'(req_ready), 0);
        if (edge_n < t_acc + L) begin
          chk("rr_busy_rsp_valid", 32'(rsp_valid), 0);
          chk("rr_mul_x", mul_x, ox);
          chk("rr_mul_y", mul_y, oy);
          chk("rr_mul_rmode", 32'(mul_rmode), 32'(eff(orm)));
        end else begin
          r = ref_mul(ox, oy, eff(orm));
          chk("rr_rsp_valid", 32'(rsp_valid), 32'(oh(og)));
          chk("rr_rsp_z", rsp_z, r[31:0]);
          chk("rr_rsp_ovrf", 32'(rsp_ovrf), 32'(r[32]));
          chk("rr_rsp_udrf", 32'(rsp_udrf), 32'(r[33]));
          chk("rr_rsp_badrm", 32'(rsp_badrm), 32'(orm > 3'd4));
          if (c >= ncyc || $urandom_range(0, 99) < p_rdy) begin
            rsp_ready = oh(og) | (N'($urandom) & ~oh(og));
            ost = 0;
          end else begin
            rsp_ready = N'($urandom) & ~oh(og);
          end
        end
      end
    end
    chk("drain_timeout", 32'(ost), 0);
    @(negedge clk);
    req_valid = '0;
    rsp_ready = '0;
    pend = '0;
    ost = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 32'h40400000, 32'h40400000, 3'd1, 32'h41100000, 1'b0, 1'b0, 1'b0, 3'd1, 0};
    tbl[1] = '{1, 32'h7F000000, 32'h7F000000, 3'd3, 32'h7F800000, 1'b1, 1'b0, 1'b0, 3'd3, 0};
    tbl[2] = '{1, 32'h00000010, 32'h00000020, 3'd6, 32'h00000030, 1'b0, 1'b0, 1'b1, 3'd0, 0};
    tbl[3] = '{2, 32'h00000010, 32'h00000020, 3'd4, 32'h00000034, 1'b0, 1'b0, 1'b0, 3'd4, 10};
    tbl[4] = '{0, 32'hFFFFFFF0, 32'h00000020, 3'd0, 32'h00000010, 1'b1, 1'b0, 1'b0, 3'd0, 2};
    tbl[5] = '{2, 32'h00000000, 32'h12345678, 3'd2, 32'h1234567A, 1'b0, 1'b1, 1'b0, 3'd2, 0};
    tbl[6] = '{1, 32'h80000000, 32'h80000000, 3'd7, 32'h00000000, 1'b1, 1'b0, 1'b1, 3'd0, 1};

    rst = 1'b1;
    req_valid = '1;
    rsp_ready = '0;
    req_x = '0; req_y = '0; req_rmode = '0;
    pend = '0; ost = 0; mptr = 0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_mul_x", mul_x, 0);
    chk("reset_mul_y", mul_y, 0);
    chk("reset_mul_rmode", 32'(mul_rmode), 0);
    chk("reset_rsp_z", rsp_z, 0);
    chk("reset_rsp_flags", {29'd0, rsp_ovrf, rsp_udrf, rsp_badrm}, 0);
    rst = 1'b0;
    req_valid = '0;

    // Two requesters continuously valid right after reset
    run_random(40, 3'b011, 100, 100, 0);
    chk("alt_grants_n", grant_log.size() >= 4 ? 1 : 0, 1);
    if (grant_log.size() >= 4) begin
      chk("alt_grant0", 32'(grant_log[0]), 0);
      chk("alt_grant1", 32'(grant_log[1]), 1);
      chk("alt_grant2", 32'(grant_log[2]), 0);
      chk("alt_grant3", 32'(grant_log[3]), 1);
    end

    for (int t = 0; t < 7; t++) single_op(tbl[t]);

    // Reset in the middle of BUSY with one latency cycle remaining
    @(posedge clk); #1;
    set_req(1, 32'hAAAA5555, 32'h12345678, 3'd2);
    req_valid = oh(1);
    @(negedge clk);
    chk("mid_grant", 32'(req_ready), 32'(oh(1)));
    @(posedge clk); #1;
    req_valid = '1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready), 0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_rst_mul_x", mul_x, 0);
    chk("mid_rst_mul_y", mul_y, 0);
    chk("mid_rst_rsp_z", rsp_z, 0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    mptr = 0;
    for (int k = 0; k < L + 3; k++) begin
      @(negedge clk);
      chk("no_stale_rsp", 32'(rsp_valid), 0);
    end
    req_valid = '1;
    #1;
    chk("ptr_after_reset", 32'(req_ready), 32'(oh(0)));
    req_valid = '0;

    // Mixed random traffic with stalls and dropped requests
    grant_log.delete();
    run_random(2000, '1, 40, 50, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
